// File: rtl/scc_mem_dump_if.sv
// Memory-read and record-stream bundle for the scc_mem_dump engine.
// The master side is the dump engine; the slave side is the memory plus the record sink.
interface scc_mem_dump_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;

    logic              rec_valid;
    logic              rec_ready;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_data;
    logic              rec_last;

    modport master (
        output mem_rd_en, mem_rd_addr, rec_valid, rec_addr, rec_data, rec_last,
        input  mem_rd_data, rec_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, rec_valid, rec_addr, rec_data, rec_last,
        output mem_rd_data, rec_ready
    );
endinterface

// File: rtl/scc_mem_dump.sv
// Halt-triggered data-memory dump engine: streams one (address, value) record per word.
// Optional macro SCC_DUMP_SKIP_ZERO_EN suppresses zero words and adds the skip_cnt output.
module scc_mem_dump #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 32'h0000_0FFC,
    parameter int unsigned       ADDR_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  halt_f,
    scc_mem_dump_if.master        bus,
    output logic                  busy,
    output logic                  done
`ifdef SCC_DUMP_SKIP_ZERO_EN
    ,
    output logic [ADDR_W-1:0]     skip_cnt
`endif
);

    localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(ADDR_STEP);
    localparam bit                EMPTY_RANGE = (END_ADDR < START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              halt_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rec_addr_q, rec_addr_d;
    logic [DATA_W-1:0] rec_data_q, rec_data_d;
    logic              rec_last_q, rec_last_d;
    logic              halt_rise;
    logic              skip_word;

    assign halt_rise = halt_f && !halt_q;

`ifdef SCC_DUMP_SKIP_ZERO_EN
    logic [ADDR_W-1:0] skip_cnt_q;

    // The final word is never skipped so the sink always receives a terminating record.
    assign skip_word = (state_q == S_WAIT) && (bus.mem_rd_data == '0) && (addr_q != END_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt_q <= '0;
        end else if (clk_en && skip_word) begin
            skip_cnt_q <= skip_cnt_q + ADDR_W'(1);
        end
    end

    assign skip_cnt = skip_cnt_q;
`else
    assign skip_word = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        rec_addr_d = rec_addr_q;
        rec_data_d = rec_data_q;
        rec_last_d = rec_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (halt_rise) begin
                    state_d = EMPTY_RANGE ? S_DONE : S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                if (skip_word) begin
                    addr_d  = addr_q + STEP;
                    state_d = S_READ;
                end else begin
                    rec_addr_d = addr_q;
                    rec_data_d = bus.mem_rd_data;
                    rec_last_d = (addr_q == END_ADDR);
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                // Compare before incrementing so the address can never wrap past END_ADDR.
                if (bus.rec_ready) begin
                    if (addr_q == END_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + STEP;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            halt_q     <= 1'b0;
            addr_q     <= START_ADDR;
            rec_addr_q <= '0;
            rec_data_q <= '0;
            rec_last_q <= 1'b0;
        end else if (clk_en) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            halt_q     <= halt_f;
            addr_q     <= addr_d;
            rec_addr_q <= rec_addr_d;
            rec_data_q <= rec_data_d;
            rec_last_q <= rec_last_d;
        end
    end

    // Outputs decode straight from state so an asserted rst clears them without a clock.
    assign bus.mem_rd_en   = (state_q == S_READ);
    assign bus.mem_rd_addr = (state_q == S_READ) ? addr_q : '0;
    assign bus.rec_valid   = (state_q == S_OUT);
    assign bus.rec_addr    = rec_addr_q;
    assign bus.rec_data    = rec_data_q;
    assign bus.rec_last    = (state_q == S_OUT) && rec_last_q;
    assign busy            = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_OUT);
    assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_scc_mem_dump.sv
// Self-checking bench for scc_mem_dump: four instances with different address ranges
// share one word memory, and a queue-based model predicts the dumped records.
module tb_scc_mem_dump;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } rec_t;

    localparam logic [31:0] ST [4] = '{32'h400, 32'h0, 32'h10, 32'h0};
    localparam logic [31:0] EN [4] = '{32'h408, 32'h0, 32'h0,  32'h3C};

`ifdef SCC_DUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        clk_en    = 1'b1;
    logic [3:0]  halt_f    = '0;
    logic [3:0]  rec_ready = '0;
    logic [31:0] mem [0:1023];

    logic        rd_en_w     [4];
    logic        rec_valid_w [4];
    logic        rec_last_w  [4];
    logic        busy_w      [4];
    logic        done_w      [4];
    logic [31:0] rd_addr_w   [4];
    logic [31:0] rec_addr_w  [4];
    logic [31:0] rec_data_w  [4];
    logic [31:0] skip_w      [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        scc_mem_dump_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        scc_mem_dump #(
            .START_ADDR (ST[g]),
            .END_ADDR   (EN[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .clk_en   (clk_en),
            .halt_f   (halt_f[g]),
            .bus      (bus.master),
            .busy     (busy_w[g]),
            .done     (done_w[g])
`ifdef SCC_DUMP_SKIP_ZERO_EN
            ,
            .skip_cnt (skip_w[g])
`endif
        );

`ifndef SCC_DUMP_SKIP_ZERO_EN
        assign skip_w[g] = '0;
`endif
        assign bus.rec_ready  = rec_ready[g];
        assign rd_en_w[g]     = bus.mem_rd_en;
        assign rd_addr_w[g]   = bus.mem_rd_addr;
        assign rec_valid_w[g] = bus.rec_valid;
        assign rec_last_w[g]  = bus.rec_last;
        assign rec_addr_w[g]  = bus.rec_addr;
        assign rec_data_w[g]  = bus.rec_data;

        // Synchronous-read memory: data appears one enabled cycle after the strobe.
        always @(posedge clk) begin
            if (clk_en && bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr[11:2]];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    // Reference: list the words in the range and drop zero words (except the last) when skipping.
    function automatic void build_exp(input logic [31:0] st, input logic [31:0] en,
                                      output rec_t q[$], output int skips, output int lead);
        q.delete();
        skips = 0;
        lead  = 0;
        for (longint a = longint'(st); a <= longint'(en); a += 4) begin
            logic [31:0] v;
            v = mem[(a >> 2) & 1023];
            if (SKIP && v == 0 && a != longint'(en)) begin
                skips++;
                if (q.size() == 0) lead++;
            end else begin
                q.push_back('{32'(a), v, a == longint'(en)});
            end
        end
    endfunction

    task automatic run_dump(input int g, input bit rand_ready, input bit stall_en,
                            input logic [31:0] stall_addr, input bit clk_stall, input string tag);
        rec_t exp[$];
        rec_t got[$];
        rec_t held;
        int   skips, lead, exp_done;
        int   cyc = 0, first_v = -1, last_acc = -1, stall_cnt = 0, rd_cnt = 0;
        bit   hold = 1'b0, stalled = 1'b0, prev_rd = 1'b0, ready;

        build_exp(ST[g], EN[g], exp, skips, lead);
        halt_f[g] = 1'b1;
        step();
        halt_f[g] = 1'b0;
        cyc = 1;
        while (!done_w[g] && cyc < 4000) begin
            if (clk_stall && !stalled && prev_rd) begin
                clk_en  = 1'b0;
                stalled = 1'b1;
                repeat (5) begin
                    step();
                    cyc++;
                    checks++;
                    if (rd_en_w[g] || rec_valid_w[g] || !busy_w[g]) begin
                        errors++;
                        $display("FAIL %s clk_en hold: rd_en=%0b valid=%0b busy=%0b, expected 0/0/1",
                                 tag, rd_en_w[g], rec_valid_w[g], busy_w[g]);
                    end
                end
                clk_en = 1'b1;
            end
            if (rd_en_w[g]) begin
                checks++;
                if (rd_addr_w[g] !== ST[g] + 32'(4 * rd_cnt)) begin
                    errors++;
                    $display("FAIL %s read addr %0d: got %h expected %h",
                             tag, rd_cnt, rd_addr_w[g], ST[g] + 32'(4 * rd_cnt));
                end
                rd_cnt++;
            end
            if (rec_valid_w[g] && first_v < 0) first_v = cyc;
            if (rec_valid_w[g]) begin
                checks++;
                if (rd_en_w[g] || !busy_w[g]) begin
                    errors++;
                    $display("FAIL %s valid phase: rd_en=%0b busy=%0b, expected 0/1", tag, rd_en_w[g], busy_w[g]);
                end
                if (hold) begin
                    checks++;
                    if (rec_addr_w[g] !== held.addr || rec_data_w[g] !== held.data || rec_last_w[g] !== held.last) begin
                        errors++;
                        $display("FAIL %s stall stability: got %h/%h/%0b expected %h/%h/%0b", tag,
                                 rec_addr_w[g], rec_data_w[g], rec_last_w[g], held.addr, held.data, held.last);
                    end
                end
            end else if (rec_last_w[g]) begin
                errors++;
                checks++;
                $display("FAIL %s rec_last without valid: got 1 expected 0", tag);
            end
            ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_en && rec_valid_w[g] && rec_addr_w[g] == stall_addr && stall_cnt < 10) begin
                ready = 1'b0;
                stall_cnt++;
            end
            rec_ready[g] = ready;
            if (rec_valid_w[g] && ready) begin
                got.push_back('{rec_addr_w[g], rec_data_w[g], rec_last_w[g]});
                last_acc = cyc;
            end
            hold    = rec_valid_w[g] && !ready;
            held    = '{rec_addr_w[g], rec_data_w[g], rec_last_w[g]};
            prev_rd = rd_en_w[g];
            step();
            cyc++;
        end
        rec_ready[g] = 1'b0;

        checks++;
        if (!done_w[g]) begin
            errors++;
            $display("FAIL %s timeout: done=%0b expected 1 within budget", tag, done_w[g]);
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL %s record count: got %0d expected %0d", tag, got.size(), exp.size());
        end
        foreach (exp[i]) begin
            if (i < got.size()) begin
                checks++;
                if (got[i].addr !== exp[i].addr || got[i].data !== exp[i].data || got[i].last !== exp[i].last) begin
                    errors++;
                    $display("FAIL %s record %0d: got %h/%h/%0b expected %h/%h/%0b", tag, i,
                             got[i].addr, got[i].data, got[i].last, exp[i].addr, exp[i].data, exp[i].last);
                end
            end
        end
        checks++;
        if (rd_cnt != exp.size() + skips) begin
            errors++;
            $display("FAIL %s read count: got %0d expected %0d", tag, rd_cnt, exp.size() + skips);
        end
        exp_done = (exp.size() > 0) ? last_acc + 1 : 1;
        checks++;
        if (cyc != exp_done) begin
            errors++;
            $display("FAIL %s done timing: got cycle %0d expected %0d", tag, cyc, exp_done);
        end
        if (!clk_stall && exp.size() > 0) begin
            checks++;
            if (first_v != 3 + 2 * lead) begin
                errors++;
                $display("FAIL %s first valid latency: got %0d expected %0d", tag, first_v, 3 + 2 * lead);
            end
        end
        if (stall_en) begin
            checks++;
            if (stall_cnt != 10) begin
                errors++;
                $display("FAIL %s stall cycles: got %0d expected 10", tag, stall_cnt);
            end
        end
        checks++;
        if (busy_w[g] || rec_valid_w[g]) begin
            errors++;
            $display("FAIL %s after done: busy=%0b valid=%0b expected 0/0", tag, busy_w[g], rec_valid_w[g]);
        end
        if (SKIP) begin
            checks++;
            if (skip_w[g] !== 32'(skips)) begin
                errors++;
                $display("FAIL %s skip_cnt: got %0d expected %0d", tag, skip_w[g], skips);
            end
        end
    endtask

    task automatic set_basic_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[32'h404 >> 2] = 32'h40;
        mem[32'h408 >> 2] = 32'h39;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (rd_en_w[g] || rd_addr_w[g] !== 0 || rec_valid_w[g] || rec_addr_w[g] !== 0 ||
                rec_data_w[g] !== 0 || rec_last_w[g] || busy_w[g] || done_w[g] || skip_w[g] !== 0) begin
                errors++;
                $display("FAIL reset outputs dut%0d: valid=%0b busy=%0b done=%0b addr=%h expected all 0",
                         g, rec_valid_w[g], busy_w[g], done_w[g], rec_addr_w[g]);
            end
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        set_basic_mem();
        run_dump(0, 1'b0, 1'b0, '0, 1'b0, "basic");
    endtask

    task automatic test_halt_ignored();
        int bad = 0;
        halt_f[0] = 1'b1;
        step();
        halt_f[0] = 1'b0;
        repeat (10) begin
            if (rd_en_w[0] || rec_valid_w[0] || busy_w[0] || !done_w[0]) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt after done: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_basic_mem();
        run_dump(0, 1'b0, 1'b1, 32'h404, 1'b0, "stall");
    endtask

    task automatic test_clk_en();
        do_reset();
        set_basic_mem();
        run_dump(0, 1'b0, 1'b0, '0, 1'b1, "clk_en");
    endtask

    task automatic test_reset_abort();
        int n = 0;
        do_reset();
        set_basic_mem();
        rec_ready[0] = 1'b1;
        halt_f[0]    = 1'b1;
        step();
        halt_f[0] = 1'b0;
        while (!(rec_valid_w[0] && rec_addr_w[0] == 32'h404) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL abort setup: record 0x404 not seen, got %0d cycles expected < 50", n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rec_valid_w[0] || rec_addr_w[0] !== 0 || rec_data_w[0] !== 0 || busy_w[0] || rd_en_w[0]) begin
            errors++;
            $display("FAIL abort async clear: valid=%0b addr=%h data=%h busy=%0b expected 0",
                     rec_valid_w[0], rec_addr_w[0], rec_data_w[0], busy_w[0]);
        end
        #2;
        rst          = 1'b0;
        rec_ready[0] = 1'b0;
        step();
        run_dump(0, 1'b0, 1'b0, '0, 1'b0, "restart");
    endtask

    task automatic test_single();
        do_reset();
        mem[0] = $urandom;
        run_dump(1, 1'b1, 1'b0, '0, 1'b0, "single");
    endtask

    task automatic test_empty();
        run_dump(2, 1'b0, 1'b0, '0, 1'b0, "empty");
    endtask

    task automatic test_halt_at_reset();
        logic [31:0] v;
        v         = $urandom | 32'h1;
        mem[0]    = v;
        rst       = 1'b1;
        halt_f[1] = 1'b1;
        #2;
        rst = 1'b0;
        step();
        step();
        step();
        checks++;
        if (!rec_valid_w[1] || rec_addr_w[1] !== 0 || rec_data_w[1] !== v || !rec_last_w[1]) begin
            errors++;
            $display("FAIL halt level at reset: valid=%0b addr=%h data=%h last=%0b expected 1/0/%h/1",
                     rec_valid_w[1], rec_addr_w[1], rec_data_w[1], rec_last_w[1], v);
        end
        rec_ready[1] = 1'b1;
        step();
        rec_ready[1] = 1'b0;
        halt_f[1]    = 1'b0;
        checks++;
        if (!done_w[1]) begin
            errors++;
            $display("FAIL halt level at reset done: got %0b expected 1", done_w[1]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            run_dump(3, 1'b1, 1'b0, '0, 1'b0, $sformatf("random%0d", r));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_halt_ignored();
        test_stall();
        test_clk_en();
        test_reset_abort();
        test_single();
        test_empty();
        test_halt_at_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scc_mem_dump.md
Name: scc_mem_dump

Overview:
- Halt-triggered data-memory dump engine for the scc_f25 core.
- On a rising edge of the processor halt flag, walks data memory from START_ADDR to END_ADDR, one word per read.
- Emits one (address, value) record per word over a valid/ready stream.
- Downstream logic (UART/log formatter or simulation sink) turns records into "0xAAAAAAAA,0xVVVVVVVV" dump lines; this is the producer side of the post-halt memory dump check.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width
- START_ADDR, 32'h0000_0000, first byte address dumped (word aligned)
- END_ADDR, 32'h0000_0FFC, last byte address dumped, inclusive (word aligned)
- ADDR_STEP, 4, byte increment between words

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- clk_en  in  1  global enable; when 0 all state, counters and outputs hold
- halt_f  in  1  processor halt flag (level); dump starts on its 0->1 edge
- mem_rd_en  out  1  data-memory read strobe
- mem_rd_addr  out  ADDR_W  data-memory read byte address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 enabled cycle after mem_rd_en
- rec_valid  out  1  record available
- rec_ready  in  1  sink accepts record
- rec_addr  out  ADDR_W  record address
- rec_data  out  DATA_W  record value
- rec_last  out  1  record is final record of dump
- busy  out  1  dump in progress
- done  out  1  dump complete, sticky until reset

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; internal address = START_ADDR; halt edge register = 0.
- All state advances only on rising clk with clk_en=1.
- FSM states:
  - IDLE: on halt_f rising edge (halt_f=1, registered previous=0) -> READ; busy=1. Level-high halt_f present at reset release counts as an edge.
  - READ: mem_rd_en=1 for exactly one cycle, mem_rd_addr=current address -> WAIT.
  - WAIT: capture mem_rd_data into rec_data, current address into rec_addr -> OUT.
  - OUT: rec_valid=1.
    - Handshake completes in a cycle with rec_valid and rec_ready both 1.
    - On handshake, if address==END_ADDR -> DONE; else address += ADDR_STEP -> READ.
    - rec_addr, rec_data and rec_last must stay stable while rec_valid=1 and rec_ready=0.
  - DONE: busy=0, done=1, rec_valid=0. No further activity until reset; further halt edges are ignored.
- Latency:
  - Halt edge to first rec_valid: 3 enabled cycles.
  - With rec_ready tied 1, one record every 3 cycles.
- rec_last=1 only on the record whose rec_addr==END_ADDR.
- rec_ready while rec_valid=0 has no effect.
- END_ADDR < START_ADDR: on the halt edge go directly IDLE->DONE with no records emitted.
- START_ADDR==END_ADDR: exactly one record, with rec_last=1.
- Address arithmetic is ADDR_W-bit unsigned; no wrap past END_ADDR is possible, because the comparison precedes the increment.
- halt_f dropping mid-dump does not abort the dump.
- rst mid-dump aborts immediately: rec_valid drops asynchronously and the next halt edge restarts from START_ADDR.
- clk_en=0 during WAIT delays capture; the memory holds its output while clk_en=0.

Optional Feature:
- Macro: SCC_DUMP_SKIP_ZERO_EN.
- When defined:
  - Words reading 0 produce no record; the FSM goes WAIT -> READ (next address) without entering OUT.
  - If the final word (END_ADDR) is zero, a record is still emitted for it with rec_last=1, so the sink always sees a terminator.
  - Adds output skip_cnt (ADDR_W), counting skipped words; it resets to 0 and is valid when done=1.
- When undefined: every word is emitted and skip_cnt does not exist.

Test Plan:
- Memory 0x404=0x40, 0x408=0x39, others 0; START=0x400, END=0x408; pulse halt_f, rec_ready=1 -> records (0x400,0x0), (0x404,0x40), (0x408,0x39,last=1); done=1 on the cycle after the last handshake; first rec_valid 3 cycles after the halt edge.
- Same setup, rec_ready held 0 for 10 cycles on record 0x404 -> rec_valid stays 1 and rec_addr/rec_data stay constant; no mem_rd_en during the stall; release -> 0x408 follows.
- START=END=0x0 -> exactly one record with rec_last=1. START=0x10, END=0x0 -> done=1 with zero records.
- Assert rst during OUT of record 0x404 -> outputs 0 immediately; re-pulse halt_f -> dump restarts at 0x400.
- clk_en=0 for 5 cycles mid-WAIT -> no state change; resulting records identical to the unstalled run.
- With SCC_DUMP_SKIP_ZERO_EN, same memory -> records (0x404,0x40), (0x408,0x39,last); skip_cnt=1.
